tlb_mmu_param: RTL and testbench
================================

// Module: tlb_mmu_param
// PURPOSE
//  Parametrised MMU: fully associative TLB (ENTRIES lines) translating N-bit logical addresses, FIFO replacement.
//  Sits between processor and data cache; on miss it reads the page-table entry from memory, refills, then forwards.
//  Adds over the fixed 8-line unit: generic depth/page size, 2-bit outcome code, flush op, illegal-op detection.
// PARAMETERS
//  N        32  address/data width
//  PAGE_W   12  offset bits; VPN = ind[N-1:PAGE_W], PPN width = N-PAGE_W
//  ENTRIES  8   TLB lines; power of two, >=2; victim pointer width = log2(ENTRIES)
//  CNT_W    16  width of statistics counters
// PORTS
//  clock    in   1     rising-edge clock
//  reset_n  in   1     asynchronous, active-low reset
//  rdyin    in   1     1-cycle request strobe from processor; op/ind/datain sampled with it
//  op       in   2     00 read, 01 write, 10 flush TLB, 11 illegal
//  ind      in   N     logical address
//  datain   in   N     write data
//  ptbase   in   N     page-table base; PTE address = ptbase + VPN (zero-extended)
//  ackout   out  1     1-cycle completion strobe to processor
//  dataout  out  N     read data, valid with ackout
//  esito    out  2     00 ok, 01 page fault, 10 cache error, 11 illegal op; valid with ackout
//  rdyoutc  out  1     1-cycle request strobe to cache
//  opoutc   out  2     copy of op (00/01)
//  indoutc  out  N     physical address {PPN, ind[PAGE_W-1:0]}
//  dataoutc out  N     copy of datain
//  ackinc   in   1     1-cycle cache completion strobe; datainc/esitoc sampled with it
//  datainc  in   N     cache read data
//  esitoc   in   1     1 = cache error
//  rdyoutm  out  1     1-cycle PTE read strobe to memory (memory op fixed to read)
//  indoutm  out  N     PTE address
//  ackinm   in   1     1-cycle memory completion strobe
//  datainm  in   N     PTE; PPN = datainm[N-PAGE_W-1:0]
//  esitom   in   1     1 = page not present (page fault)
//  hit_cnt  out  CNT_W TLB hits (see CONFIGURATION)
//  miss_cnt out  CNT_W TLB misses
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, all valid bits 0, victim pointer 0, counters 0. Reset mid-operation aborts;
//   late ackinc/ackinm after reset are ignored in IDLE.
//  FSM: IDLE -> LOOK -> {PTW -> REFILL} -> CACHE -> RESP -> IDLE. Output strobes are registered, high exactly 1 cycle.
//  IDLE: on rdyin latch op/ind/datain; next LOOK. rdyin outside IDLE is ignored (no queuing).
//  LOOK: compare VPN against all valid lines.
//   op=11 -> RESP esito=11. op=10 -> clear all valid bits, pointer=0, RESP esito=00.
//   hit -> CACHE (rdyoutc next cycle). miss -> PTW (rdyoutm, indoutm=ptbase+VPN, next cycle).
//   Multiple hits cannot arise; if present, lowest index wins.
//  PTW: wait ackinm (unbounded). esitom=1 -> RESP esito=01, TLB unchanged, no cache access.
//   esitom=0 -> REFILL: line[ptr] <= {VPN, PPN}, valid=1, ptr <= ptr+1 mod ENTRIES (wraps ENTRIES-1 -> 0); then CACHE.
//  CACHE: rdyoutc with PPN from hit line or refilled PPN; wait ackinc. esitoc=1 -> esito=10 else 00; dataout<=datainc.
//  RESP: ackout pulse with esito/dataout; dataout holds until next ackout. Next cycle IDLE.
//  Latency (rdyin at cycle 0): hit -> rdyoutc cycle 2; ackinc cycle k -> ackout k+1.
//   Miss -> rdyoutm cycle 2; ackinm cycle m -> rdyoutc m+2. Flush/illegal -> ackout cycle 2.
//  Write ops do not alter TLB contents; no dirty/permission bits.
//  Arithmetic: ptbase+VPN modulo 2^N, carry dropped.
// CONFIGURATION
//  TLB_STATS_EN defined: hit_cnt/miss_cnt increment in LOOK on hit/miss of op 00/01;
//   saturate at all-ones; flush does not clear them.
//  Not defined: counter logic omitted, hit_cnt/miss_cnt tied to 0.
// TESTING
//  1 Reset, ptbase=0x1000, read ind=0x00003ABC -> rdyoutm, indoutm=0x1003; datainm=0x55, esitom=0
//    -> rdyoutc, indoutc=0x00055ABC; ackinc datainc=0xCAFE -> ackout, dataout=0xCAFE, esito=00.
//  2 Repeat read ind=0x00003010 -> no rdyoutm; rdyoutc cycle 2, indoutc=0x00055010; hit_cnt=1, miss_cnt=1 (stats on).
//  3 Miss with esitom=1 -> ackout esito=01, no rdyoutc; re-read same page misses again.
//  4 Fill VPN 0..8 (ENTRIES=8) -> 9th refill overwrites line 0; VPN0 misses, VPN1 hits.
//  5 op=10 after fills -> ackout cycle 2 esito=00; every prior VPN misses; next refill to line 0.
//  6 op=11 -> esito=11, no strobes out; ackinc=1 in CACHE with esitoc=1 -> esito=10; reset_n low during PTW -> all outputs 0.

Source files
------------

// File: rtl/tlb_mmu_param.sv
// tlb_mmu_param: fully associative TLB/MMU between processor and data cache.
// Translates N-bit logical addresses via ENTRIES lines with FIFO replacement;
// on a miss it fetches the PTE from memory, refills, then forwards to cache.
// Optional hit/miss statistics counters: define TLB_STATS_EN to build them.
module tlb_mmu_param #(
  parameter int N       = 32,
  parameter int PAGE_W  = 12,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rdyin,
  input  logic [1:0]       op,
  input  logic [N-1:0]     ind,
  input  logic [N-1:0]     datain,
  input  logic [N-1:0]     ptbase,
  output logic             ackout,
  output logic [N-1:0]     dataout,
  output logic [1:0]       esito,
  output logic             rdyoutc,
  output logic [1:0]       opoutc,
  output logic [N-1:0]     indoutc,
  output logic [N-1:0]     dataoutc,
  input  logic             ackinc,
  input  logic [N-1:0]     datainc,
  input  logic             esitoc,
  output logic             rdyoutm,
  output logic [N-1:0]     indoutm,
  input  logic             ackinm,
  input  logic [N-1:0]     datainm,
  input  logic             esitom,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int VPN_W = N - PAGE_W;
  localparam int PTR_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOK, S_PTW, S_REFILL, S_CACHE, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [N-1:0]        ind_q, ind_d;
  logic [N-1:0]        dat_q, dat_d;
  logic [VPN_W-1:0]    pte_ppn_q, pte_ppn_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic                ackout_q, ackout_d;
  logic [N-1:0]        dataout_q, dataout_d;
  logic [1:0]          esito_q, esito_d;
  logic                rdyoutc_q, rdyoutc_d;
  logic [1:0]          opoutc_q, opoutc_d;
  logic [N-1:0]        indoutc_q, indoutc_d;
  logic [N-1:0]        dataoutc_q, dataoutc_d;
  logic                rdyoutm_q, rdyoutm_d;
  logic [N-1:0]        indoutm_q, indoutm_d;

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][VPN_W-1:0] tag_q;
  logic [ENTRIES-1:0][VPN_W-1:0] ppn_q;

  logic             tlb_we, tlb_flush;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic [VPN_W-1:0] vpn;

  // Only the PPN field of the PTE is meaningful; upper bits are ignored.
  logic unused_pte_hi;
  assign unused_pte_hi = ^datainm[N-1:VPN_W];

  assign vpn = ind_q[N-1:PAGE_W];

  // Associative compare; scanning downward makes the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == vpn) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // Next-state and registered-output logic; strobes default low so each pulse lasts one cycle.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ind_d      = ind_q;
    dat_d      = dat_q;
    pte_ppn_d  = pte_ppn_q;
    ptr_d      = ptr_q;
    ackout_d   = 1'b0;
    dataout_d  = dataout_q;
    esito_d    = esito_q;
    rdyoutc_d  = 1'b0;
    opoutc_d   = opoutc_q;
    indoutc_d  = indoutc_q;
    dataoutc_d = dataoutc_q;
    rdyoutm_d  = 1'b0;
    indoutm_d  = indoutm_q;
    tlb_we     = 1'b0;
    tlb_flush  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rdyin) begin
          op_d    = op;
          ind_d   = ind;
          dat_d   = datain;
          state_d = S_LOOK;
        end
      end
      S_LOOK: begin
        if (op_q == 2'b11) begin
          esito_d  = 2'b11;
          ackout_d = 1'b1;
          state_d  = S_RESP;
        end else if (op_q == 2'b10) begin
          tlb_flush = 1'b1;
          ptr_d     = '0;
          esito_d   = 2'b00;
          ackout_d  = 1'b1;
          state_d   = S_RESP;
        end else if (hit) begin
          rdyoutc_d  = 1'b1;
          opoutc_d   = op_q;
          indoutc_d  = {ppn_q[hit_idx], ind_q[PAGE_W-1:0]};
          dataoutc_d = dat_q;
          state_d    = S_CACHE;
        end else begin
          rdyoutm_d = 1'b1;
          indoutm_d = ptbase + N'(vpn);
          state_d   = S_PTW;
        end
      end
      S_PTW: begin
        if (ackinm) begin
          if (esitom) begin
            esito_d  = 2'b01;
            ackout_d = 1'b1;
            state_d  = S_RESP;
          end else begin
            pte_ppn_d = datainm[VPN_W-1:0];
            state_d   = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        tlb_we     = 1'b1;
        ptr_d      = ptr_q + PTR_W'(1);
        rdyoutc_d  = 1'b1;
        opoutc_d   = op_q;
        indoutc_d  = {pte_ppn_q, ind_q[PAGE_W-1:0]};
        dataoutc_d = dat_q;
        state_d    = S_CACHE;
      end
      S_CACHE: begin
        if (ackinc) begin
          dataout_d = datainc;
          esito_d   = esitoc ? 2'b10 : 2'b00;
          ackout_d  = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      ind_q      <= '0;
      dat_q      <= '0;
      pte_ppn_q  <= '0;
      ptr_q      <= '0;
      ackout_q   <= 1'b0;
      dataout_q  <= '0;
      esito_q    <= '0;
      rdyoutc_q  <= 1'b0;
      opoutc_q   <= '0;
      indoutc_q  <= '0;
      dataoutc_q <= '0;
      rdyoutm_q  <= 1'b0;
      indoutm_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ind_q      <= ind_d;
      dat_q      <= dat_d;
      pte_ppn_q  <= pte_ppn_d;
      ptr_q      <= ptr_d;
      ackout_q   <= ackout_d;
      dataout_q  <= dataout_d;
      esito_q    <= esito_d;
      rdyoutc_q  <= rdyoutc_d;
      opoutc_q   <= opoutc_d;
      indoutc_q  <= indoutc_d;
      dataoutc_q <= dataoutc_d;
      rdyoutm_q  <= rdyoutm_d;
      indoutm_q  <= indoutm_d;
    end
  end

  // TLB lines: flush drops every valid bit, refill writes the line at the FIFO pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      ppn_q   <= '0;
    end else if (tlb_flush) begin
      valid_q <= '0;
    end else if (tlb_we) begin
      valid_q[ptr_q] <= 1'b1;
      tag_q[ptr_q]   <= vpn;
      ppn_q[ptr_q]   <= pte_ppn_q;
    end
  end

`ifdef TLB_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  // Count read/write lookups only; counters stick at all-ones and survive flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOK && !op_q[1]) begin
      if (hit && !(&hit_cnt_q))
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (!hit && !(&miss_cnt_q))
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

  assign ackout   = ackout_q;
  assign dataout  = dataout_q;
  assign esito    = esito_q;
  assign rdyoutc  = rdyoutc_q;
  assign opoutc   = opoutc_q;
  assign indoutc  = indoutc_q;
  assign dataoutc = dataoutc_q;
  assign rdyoutm  = rdyoutm_q;
  assign indoutm  = indoutm_q;

endmodule

// File: tb/tb_tlb_mmu_param.sv
// Bench for tlb_mmu_param: directed vector table, hand sequences for FIFO
// replacement / flush / mid-walk reset, then randomized traffic against a
// queue-based TLB reference model.
module tb_tlb_mmu_param;
  localparam int N = 32, PAGE_W = 12, ENTRIES = 8, CNT_W = 16;
`ifdef TLB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock, reset_n, rdyin, ackout, rdyoutc, ackinc, esitoc, rdyoutm, ackinm, esitom;
  logic [1:0] op, esito, opoutc;
  logic [N-1:0] ind, datain, ptbase, dataout, indoutc, dataoutc, datainc, indoutm, datainm;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  tlb_mmu_param #(.N(N), .PAGE_W(PAGE_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .rdyin(rdyin), .op(op), .ind(ind), .datain(datain),
    .ptbase(ptbase), .ackout(ackout), .dataout(dataout), .esito(esito), .rdyoutc(rdyoutc),
    .opoutc(opoutc), .indoutc(indoutc), .dataoutc(dataoutc), .ackinc(ackinc), .datainc(datainc),
    .esitoc(esitoc), .rdyoutm(rdyoutm), .indoutm(indoutm), .ackinm(ackinm), .datainm(datainm),
    .esitom(esitom), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    bit         miss;
    bit         cache;
    logic [31:0] indm;
    logic [31:0] indc;
    logic [31:0] dout;
    logic [1:0]  esito;
  } exp_t;

  typedef struct packed {
    int nm; int nc; int m_cyc; int c_cyc; int a_cyc; int am_cyc; int ac_cyc;
    logic [31:0] indm; logic [31:0] indc; logic [31:0] datc; logic [31:0] dout;
    logic [1:0] opc; logic [1:0] esito;
  } obs_t;

  typedef struct {
    logic [1:0] op; logic [31:0] ind; logic [31:0] din; logic [31:0] pb; logic [31:0] pte;
    bit fault; bit cerr; logic [31:0] cdat; exp_t e;
  } vec_t;

  typedef struct packed { logic [19:0] vpn; logic [19:0] ppn; } line_t;

  int checks = 0, failures = 0;
  line_t tlbq[$];
  int m_hits = 0, m_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".strobes"}, {ackout, rdyoutc, rdyoutm}, 0);
    chk({tag, ".data"}, {dataout, dataoutc}, 0);
    chk({tag, ".addr"}, {indoutc, indoutm}, 0);
    chk({tag, ".misc"}, {esito, opoutc, hit_cnt, miss_cnt}, 0);
  endtask

  task automatic model_clear();
    tlbq.delete();
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0; rdyin = 1'b0; ackinm = 1'b0; ackinc = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 check_zero(tag);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // Reference TLB: a FIFO of {vpn,ppn}; the oldest entry is evicted when full.
  task automatic model_txn(input logic [1:0] t_op, input logic [31:0] t_ind, t_pb, t_pte,
                           input bit t_fault, t_cerr, input logic [31:0] t_cdat, output exp_t e);
    logic [19:0] v;
    int idx;
    e = '0; v = t_ind[31:12]; idx = -1;
    if (t_op == 2'b11) e.esito = 2'b11;
    else if (t_op == 2'b10) begin
      tlbq.delete();
      e.esito = 2'b00;
    end else begin
      foreach (tlbq[i]) if (tlbq[i].vpn == v) idx = i;
      if (idx >= 0) begin
        m_hits++;
        e.cache = 1'b1;
        e.indc = {tlbq[idx].ppn, t_ind[11:0]};
      end else begin
        m_miss++;
        e.miss = 1'b1;
        e.indm = t_pb + {12'h0, v};
        if (t_fault) e.esito = 2'b01;
        else begin
          if (tlbq.size() == ENTRIES) tlbq.delete(0);
          tlbq.push_back({v, t_pte[19:0]});
          e.cache = 1'b1;
          e.indc = {t_pte[19:0], t_ind[11:0]};
        end
      end
      if (e.cache) begin
        e.esito = t_cerr ? 2'b10 : 2'b00;
        e.dout = t_cdat;
      end
    end
  endtask

  // Issue one request and play the memory/cache responders; cycle 0 = rdyin cycle.
  task automatic run_txn(input logic [1:0] t_op, input logic [31:0] t_ind, t_din, t_pte,
                         input bit t_fault, t_cerr, input logic [31:0] t_cdat,
                         input int mdly, cdly, input bit noise, output obs_t o);
    int mack, cack;
    bit done;
    o = '0; mack = -1; cack = -1; done = 1'b0;
    op = t_op; ind = t_ind; datain = t_din; rdyin = 1'b1;
    @(posedge clock); #1 rdyin = 1'b0;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      @(negedge clock);
      if (rdyoutm) begin o.nm++; o.m_cyc = cyc; o.indm = indoutm; mack = cyc + mdly; end
      if (rdyoutc) begin
        o.nc++; o.c_cyc = cyc; o.indc = indoutc; o.opc = opoutc; o.datc = dataoutc;
        cack = cyc + cdly;
      end
      if (ackout) begin o.a_cyc = cyc; o.esito = esito; o.dout = dataout; done = 1'b1; end
      ackinm = (cyc == mack);
      datainm = ackinm ? t_pte : $urandom;
      esitom = ackinm ? t_fault : 1'($urandom);
      if (ackinm) o.am_cyc = cyc;
      ackinc = (cyc == cack);
      datainc = ackinc ? t_cdat : $urandom;
      esitoc = ackinc ? t_cerr : 1'($urandom);
      if (ackinc) o.ac_cyc = cyc;
      rdyin = noise && !done && ($urandom_range(0, 3) == 0);
      op = 2'($urandom);
      ind = $urandom;
    end
    ackinm = 1'b0; ackinc = 1'b0; rdyin = 1'b0;
    if (!done) $display("FAIL timeout: no ackout within bound (op=%0d ind=%h)", t_op, t_ind);
    @(posedge clock); #1;
  endtask

  task automatic check_txn(input string tag, input logic [1:0] t_op, input logic [31:0] t_din,
                           input exp_t e, input obs_t o);
    chk({tag, ".ack"}, o.a_cyc > 0, 1);
    chk({tag, ".esito"}, o.esito, e.esito);
    chk({tag, ".nreqm"}, o.nm, e.miss);
    chk({tag, ".nreqc"}, o.nc, e.cache);
    if (e.miss) begin
      chk({tag, ".m_cyc"}, o.m_cyc, 2);
      chk({tag, ".indm"}, o.indm, e.indm);
    end
    if (e.cache) begin
      chk({tag, ".indc"}, o.indc, e.indc);
      chk({tag, ".opc"}, o.opc, t_op);
      chk({tag, ".datc"}, o.datc, t_din);
      chk({tag, ".c_cyc"}, o.c_cyc, e.miss ? o.am_cyc + 2 : 2);
      chk({tag, ".a_cyc"}, o.a_cyc, o.ac_cyc + 1);
      chk({tag, ".dout"}, o.dout, e.dout);
    end else if (e.miss) chk({tag, ".a_cyc"}, o.a_cyc, o.am_cyc + 1);
    else chk({tag, ".a_cyc"}, o.a_cyc, 2);
  endtask

  task automatic do_model(input string tag, input logic [1:0] t_op, input logic [31:0] t_ind,
                          t_din, t_pte, input bit t_fault, t_cerr, input logic [31:0] t_cdat,
                          input int mdly, cdly, input bit noise, output obs_t o);
    exp_t e;
    model_txn(t_op, t_ind, ptbase, t_pte, t_fault, t_cerr, t_cdat, e);
    run_txn(t_op, t_ind, t_din, t_pte, t_fault, t_cerr, t_cdat, mdly, cdly, noise, o);
    check_txn(tag, t_op, t_din, e, o);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".hit_cnt"}, hit_cnt, STATS ? m_hits : 0);
    chk({tag, ".miss_cnt"}, miss_cnt, STATS ? m_miss : 0);
  endtask

  vec_t tbl[9];
  obs_t o;
  bit seen;

  initial begin
    reset_n = 1'b0; rdyin = 1'b0; op = '0; ind = '0; datain = '0; ptbase = '0;
    ackinc = 1'b0; datainc = '0; esitoc = 1'b0; ackinm = 1'b0; datainm = '0; esitom = 1'b0;

    //        op     ind            din           pb            pte           flt  cerr cdat           miss cache indm          indc          dout          esito
    tbl[0] = '{2'b00, 32'h00003ABC, 32'h0,        32'h1000,     32'h55,       0, 0, 32'hCAFE, '{1, 1, 32'h1003,     32'h00055ABC, 32'hCAFE, 2'b00}};
    tbl[1] = '{2'b00, 32'h00003010, 32'h0,        32'h1000,     32'h0,        0, 0, 32'h1234, '{0, 1, 32'h0,        32'h00055010, 32'h1234, 2'b00}};
    tbl[2] = '{2'b01, 32'h00007123, 32'hDEAD,     32'h1000,     32'h0,        1, 0, 32'h0,    '{1, 0, 32'h1007,     32'h0,        32'h0,    2'b01}};
    tbl[3] = '{2'b00, 32'h00007000, 32'h0,        32'h1000,     32'h0,        1, 0, 32'h0,    '{1, 0, 32'h1007,     32'h0,        32'h0,    2'b01}};
    tbl[4] = '{2'b11, 32'h00003ABC, 32'h0,        32'h1000,     32'h0,        0, 0, 32'h0,    '{0, 0, 32'h0,        32'h0,        32'h0,    2'b11}};
    tbl[5] = '{2'b00, 32'h00003FFF, 32'h0,        32'h1000,     32'h0,        0, 1, 32'hBEEF, '{0, 1, 32'h0,        32'h00055FFF, 32'hBEEF, 2'b10}};
    tbl[6] = '{2'b10, 32'h00003ABC, 32'h0,        32'h1000,     32'h0,        0, 0, 32'h0,    '{0, 0, 32'h0,        32'h0,        32'h0,    2'b00}};
    tbl[7] = '{2'b01, 32'h00003ABC, 32'h77,       32'h1000,     32'hFFFFF066, 0, 0, 32'h99,   '{1, 1, 32'h1003,     32'hFF066ABC, 32'h99,   2'b00}};
    tbl[8] = '{2'b00, 32'h00010000, 32'h0,        32'hFFFFFFF8, 32'h3,        0, 0, 32'h5,    '{1, 1, 32'h00000008, 32'h00003000, 32'h5,    2'b00}};

    do_reset("reset");

    for (int i = 0; i < 9; i++) begin
      ptbase = tbl[i].pb;
      run_txn(tbl[i].op, tbl[i].ind, tbl[i].din, tbl[i].pte, tbl[i].fault, tbl[i].cerr,
              tbl[i].cdat, 1 + (i % 3), 1 + (i % 2), 1'b0, o);
      check_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].din, tbl[i].e, o);
      if (i == 1) begin
        chk("vec1.hit_cnt", hit_cnt, STATS ? 1 : 0);
        chk("vec1.miss_cnt", miss_cnt, STATS ? 1 : 0);
      end
    end
    chk("vec.hit_cnt", hit_cnt, STATS ? 2 : 0);
    chk("vec.miss_cnt", miss_cnt, STATS ? 5 : 0);

    // FIFO replacement: nine fills wrap onto line 0.
    do_reset("reset2");
    ptbase = 32'h4000;
    for (int v = 0; v < 9; v++)
      do_model($sformatf("fill%0d", v), 2'b00, {20'(v), 12'h0}, 32'h0, 32'h100 + v, 0, 0,
               32'h10 + v, 1, 1, 1'b0, o);
    do_model("fifo.vpn1", 2'b00, {20'd1, 12'h004}, 32'h0, 32'h0, 0, 0, 32'hA1, 2, 1, 1'b0, o);
    chk("fifo.vpn1_hit", o.nm, 0);
    do_model("fifo.vpn0", 2'b00, {20'd0, 12'h008}, 32'h0, 32'h200, 0, 0, 32'hA0, 1, 2, 1'b0, o);
    chk("fifo.vpn0_miss", o.nm, 1);

    // Flush: every previously mapped page misses afterwards.
    do_model("flush", 2'b10, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1, 1'b0, o);
    for (int v = 0; v < 8; v++) begin
      do_model($sformatf("postflush%0d", v), 2'b01, {20'(v), 12'h0}, 32'h5A, 32'h300 + v, 0, 0,
               32'h0, 1, 1, 1'b0, o);
      chk($sformatf("postflush%0d.miss", v), o.nm, 1);
    end
    do_model("postflush.rehit", 2'b00, {20'd0, 12'hFFF}, 32'h0, 32'h0, 0, 0, 32'h77, 1, 1, 1'b0, o);
    chk("postflush.rehit_hit", o.nm, 0);

    // Reset while waiting for the page-table read; late acks must be ignored.
    ptbase = 32'h2000; op = 2'b00; ind = 32'h00042000; rdyin = 1'b1;
    @(posedge clock); #1 rdyin = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      seen = rdyoutm;
    end
    chk("rstptw.req", seen, 1);
    reset_n = 1'b0;
    model_clear();
    #1 check_zero("rstptw");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ackinm = 1'b1; esitom = 1'b0; datainm = 32'h123; ackinc = 1'b1; datainc = 32'h456;
    @(negedge clock);
    ackinm = 1'b0; ackinc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("rstptw.quiet%0d", c), {ackout, rdyoutc, rdyoutm}, 0);
    end
    @(posedge clock); #1;
    do_model("rstptw.again", 2'b00, 32'h00042000, 32'h0, 32'h9, 0, 0, 32'h1, 1, 1, 1'b0, o);
    chk("rstptw.again_miss", o.nm, 1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      int r, vi;
      logic [1:0] rop;
      logic [19:0] v;
      r = $urandom_range(0, 19);
      rop = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : {1'b0, 1'(r)};
      vi = $urandom_range(0, 11);
      v = 20'(vi * 32'h1111);
      ptbase = $urandom;
      do_model($sformatf("rnd%0d", n), rop, {v, 12'($urandom)}, $urandom, $urandom,
               $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, o);
    end
    check_stats("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
